// File: rtl/cv32e40p_rf_recovery_pkg.sv
// Shared types and widths for the register-file recovery unit.
//   rf_rec_state_e : controller states (TRACK, SNAPSHOT, SETBACK, RESTORE)
//   RF_DATA_W      : core register width
//   RF_ADDR_W      : core register-file address width (matches regfile_waddr_*)
//   SNAP_LANES     : read lanes used per snapshot cycle
package cv32e40p_rf_recovery_pkg;

    localparam int unsigned RF_DATA_W  = 32;
    localparam int unsigned RF_ADDR_W  = 6;
    localparam int unsigned SNAP_LANES = 3;

    typedef enum logic [1:0] {
        TRACK,
        SNAPSHOT,
        SETBACK,
        RESTORE
    } rf_rec_state_e;

endpackage

// File: rtl/cv32e40p_rf_recovery_unit_if.sv
// Bundle of the core-facing register-file recovery signals.
//   core_*_i   : core RF write outputs observed by the recovery unit
//   setback_o / recover_o : core control
//   rf_*_o     : recovery write ports into the core RF
//   backup_o, raddr_r*_o / rdata_r*_i : backup read ports of the core RF
// master = recovery unit side, slave = core side.
interface cv32e40p_rf_recovery_unit_if;
    import cv32e40p_rf_recovery_pkg::*;

    logic                 core_we_a_i;
    logic [RF_ADDR_W-1:0] core_waddr_a_i;
    logic [RF_DATA_W-1:0] core_wdata_a_i;
    logic                 core_we_b_i;
    logic [RF_ADDR_W-1:0] core_waddr_b_i;
    logic [RF_DATA_W-1:0] core_wdata_b_i;

    logic                 setback_o;
    logic                 recover_o;

    logic                 rf_we_a_o;
    logic [RF_ADDR_W-1:0] rf_waddr_a_o;
    logic [RF_DATA_W-1:0] rf_wdata_a_o;
    logic                 rf_we_b_o;
    logic [RF_ADDR_W-1:0] rf_waddr_b_o;
    logic [RF_DATA_W-1:0] rf_wdata_b_o;

    logic                 backup_o;
    logic [RF_ADDR_W-1:0] raddr_ra_o;
    logic [RF_ADDR_W-1:0] raddr_rb_o;
    logic [RF_ADDR_W-1:0] raddr_rc_o;
    logic [RF_DATA_W-1:0] rdata_ra_i;
    logic [RF_DATA_W-1:0] rdata_rb_i;
    logic [RF_DATA_W-1:0] rdata_rc_i;

    modport master (
        input  core_we_a_i, core_waddr_a_i, core_wdata_a_i,
        input  core_we_b_i, core_waddr_b_i, core_wdata_b_i,
        output setback_o, recover_o,
        output rf_we_a_o, rf_waddr_a_o, rf_wdata_a_o,
        output rf_we_b_o, rf_waddr_b_o, rf_wdata_b_o,
        output backup_o, raddr_ra_o, raddr_rb_o, raddr_rc_o,
        input  rdata_ra_i, rdata_rb_i, rdata_rc_i
    );

    modport slave (
        output core_we_a_i, core_waddr_a_i, core_wdata_a_i,
        output core_we_b_i, core_waddr_b_i, core_wdata_b_i,
        input  setback_o, recover_o,
        input  rf_we_a_o, rf_waddr_a_o, rf_wdata_a_o,
        input  rf_we_b_o, rf_waddr_b_o, rf_wdata_b_o,
        input  backup_o, raddr_ra_o, raddr_rb_o, raddr_rc_o,
        output rdata_ra_i, rdata_rb_i, rdata_rc_i
    );

endinterface

// File: rtl/cv32e40p_rf_shadow.sv
// Shadow copy of the core register file.
//   clk_i, rst_i             : clock, synchronous active-high clear
//   we/waddr/wdata _a/_b     : tracking write ports, B overrides A on same address
//   snap_we/waddr/wdata      : snapshot lane write ports
//   raddr/rdata _a/_b        : combinational read ports (0 for out-of-range)
// Entry 0 is never written; out-of-range addresses match no entry.
module cv32e40p_rf_shadow
    import cv32e40p_rf_recovery_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = RF_ADDR_W
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 we_a_i,
    input  logic [ADDR_W-1:0]                    waddr_a_i,
    input  logic [RF_DATA_W-1:0]                 wdata_a_i,
    input  logic                                 we_b_i,
    input  logic [ADDR_W-1:0]                    waddr_b_i,
    input  logic [RF_DATA_W-1:0]                 wdata_b_i,
    input  logic [SNAP_LANES-1:0]                snap_we_i,
    input  logic [SNAP_LANES-1:0][ADDR_W-1:0]    snap_waddr_i,
    input  logic [SNAP_LANES-1:0][RF_DATA_W-1:0] snap_wdata_i,
    input  logic [ADDR_W-1:0]                    raddr_a_i,
    output logic [RF_DATA_W-1:0]                 rdata_a_o,
    input  logic [ADDR_W-1:0]                    raddr_b_i,
    output logic [RF_DATA_W-1:0]                 rdata_b_o
);

    logic [RF_DATA_W-1:0] mem_q [NUM_REGS];
    logic [RF_DATA_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        // Loop starts at 1 so x0 can never be written.
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (we_a_i && (waddr_a_i == ADDR_W'(r))) mem_d[r] = wdata_a_i;
            if (we_b_i && (waddr_b_i == ADDR_W'(r))) mem_d[r] = wdata_b_i;
            for (int unsigned l = 0; l < SNAP_LANES; l++) begin
                if (snap_we_i[l] && (snap_waddr_i[l] == ADDR_W'(r))) mem_d[r] = snap_wdata_i[l];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (raddr_a_i == ADDR_W'(r)) rdata_a_o = mem_q[r];
            if (raddr_b_i == ADDR_W'(r)) rdata_b_o = mem_q[r];
        end
    end

endmodule

// File: rtl/cv32e40p_rf_recovery_unit.sv
// Register-file recovery controller placed beside the CV32E40P core.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   snapshot_req_i   : pulse, copy core RF into the shadow via backup reads
//   recover_req_i    : pulse, setback the core and restore the shadow into it
//   busy_o           : high whenever not tracking
//   done_o           : one-cycle pulse at the end of a snapshot or restore
//   rf_if            : core-facing RF bundle (master side)
module cv32e40p_rf_recovery_unit
    import cv32e40p_rf_recovery_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = RF_ADDR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         snapshot_req_i,
    input  logic                         recover_req_i,
    output logic                         busy_o,
    output logic                         done_o,
    cv32e40p_rf_recovery_unit_if.master  rf_if
);

    // One extra bit so snapshot lane addresses past the RF never wrap onto low entries.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_REGS);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(NUM_REGS / 2);

    rf_rec_state_e state_q, state_d;
    logic                 pending_q, pending_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 setback_q, setback_d;
    logic                 recover_q, recover_d;
    logic                 backup_q, backup_d;
    logic                 rf_we_a_q, rf_we_a_d;
    logic                 rf_we_b_q, rf_we_b_d;
    logic [ADDR_W-1:0]    rf_waddr_a_q, rf_waddr_a_d;
    logic [ADDR_W-1:0]    rf_waddr_b_q, rf_waddr_b_d;
    logic [RF_DATA_W-1:0] rf_wdata_a_q, rf_wdata_a_d;
    logic [RF_DATA_W-1:0] rf_wdata_b_q, rf_wdata_b_d;
    logic [ADDR_W-1:0]    raddr_ra_q, raddr_ra_d;
    logic [ADDR_W-1:0]    raddr_rb_q, raddr_rb_d;
    logic [ADDR_W-1:0]    raddr_rc_q, raddr_rc_d;

    logic                                 trk_we_a, trk_we_b;
    logic [SNAP_LANES-1:0]                snap_we;
    logic [SNAP_LANES-1:0][ADDR_W-1:0]    snap_waddr;
    logic [SNAP_LANES-1:0][RF_DATA_W-1:0] snap_wdata;
    logic [ADDR_W-1:0]                    rd_addr_a, rd_addr_b;
    logic [RF_DATA_W-1:0]                 rd_data_a, rd_data_b;
    logic [CNT_W-1:0]                     snap_next;

    // Tracking only in TRACK; shadow is frozen from SETBACK onwards.
    assign trk_we_a = rf_if.core_we_a_i && (state_q == TRACK);
    assign trk_we_b = rf_if.core_we_b_i && (state_q == TRACK);

    // Snapshot lanes follow the registered read addresses, data arrives in the same cycle.
    assign snap_wdata = {rf_if.rdata_rc_i, rf_if.rdata_rb_i, rf_if.rdata_ra_i};
    always_comb begin
        snap_we    = '0;
        snap_waddr = '0;
        for (int unsigned l = 0; l < SNAP_LANES; l++) begin
            snap_we[l]    = (state_q == SNAPSHOT) && ((cnt_q + CNT_W'(l)) < NUM_C);
            snap_waddr[l] = ADDR_W'(cnt_q + CNT_W'(l));
        end
    end

    assign snap_next = cnt_q + CNT_W'(SNAP_LANES);
    assign rd_addr_a = {cnt_q[ADDR_W-2:0], 1'b0};
    assign rd_addr_b = {cnt_q[ADDR_W-2:0], 1'b1};

    cv32e40p_rf_shadow #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_shadow (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .we_a_i       (trk_we_a),
        .waddr_a_i    (rf_if.core_waddr_a_i),
        .wdata_a_i    (rf_if.core_wdata_a_i),
        .we_b_i       (trk_we_b),
        .waddr_b_i    (rf_if.core_waddr_b_i),
        .wdata_b_i    (rf_if.core_wdata_b_i),
        .snap_we_i    (snap_we),
        .snap_waddr_i (snap_waddr),
        .snap_wdata_i (snap_wdata),
        .raddr_a_i    (rd_addr_a),
        .rdata_a_o    (rd_data_a),
        .raddr_b_i    (rd_addr_b),
        .rdata_b_o    (rd_data_b)
    );

    // Next-state and next-output logic; every output is the registered copy of its _d.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        setback_d    = 1'b0;
        recover_d    = 1'b0;
        backup_d     = 1'b0;
        rf_we_a_d    = 1'b0;
        rf_we_b_d    = 1'b0;
        rf_waddr_a_d = '0;
        rf_waddr_b_d = '0;
        rf_wdata_a_d = '0;
        rf_wdata_b_d = '0;
        raddr_ra_d   = '0;
        raddr_rb_d   = '0;
        raddr_rc_d   = '0;

        case (state_q)
            TRACK: begin
                if (recover_req_i) begin
                    state_d   = SETBACK;
                    setback_d = 1'b1;
                    cnt_d     = '0;
                end else if (snapshot_req_i) begin
                    state_d    = SNAPSHOT;
                    backup_d   = 1'b1;
                    cnt_d      = '0;
                    raddr_ra_d = ADDR_W'(0);
                    raddr_rb_d = ADDR_W'(1);
                    raddr_rc_d = ADDR_W'(2);
                end
            end
            SNAPSHOT: begin
                pending_d = pending_q | recover_req_i;
                if (snap_next >= NUM_C) begin
                    pending_d = 1'b0;
                    // A recovery raised during the snapshot replaces its done pulse.
                    if (pending_q || recover_req_i) begin
                        state_d   = SETBACK;
                        setback_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d = TRACK;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d      = snap_next;
                    backup_d   = 1'b1;
                    raddr_ra_d = ADDR_W'(snap_next);
                    raddr_rb_d = ADDR_W'(snap_next + CNT_W'(1));
                    raddr_rc_d = ADDR_W'(snap_next + CNT_W'(2));
                end
            end
            SETBACK, RESTORE: begin
                if ((state_q == RESTORE) && (cnt_q == HALF_C)) begin
                    state_d = TRACK;
                    done_d  = 1'b1;
                end else begin
                    state_d      = RESTORE;
                    recover_d    = 1'b1;
                    rf_we_a_d    = 1'b1;
                    rf_we_b_d    = 1'b1;
                    rf_waddr_a_d = rd_addr_a;
                    rf_waddr_b_d = rd_addr_b;
                    rf_wdata_a_d = rd_data_a;
                    rf_wdata_b_d = rd_data_b;
                    cnt_d        = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = TRACK;
        endcase

        busy_d = (state_d != TRACK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= TRACK;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            setback_q    <= 1'b0;
            recover_q    <= 1'b0;
            backup_q     <= 1'b0;
            rf_we_a_q    <= 1'b0;
            rf_we_b_q    <= 1'b0;
            rf_waddr_a_q <= '0;
            rf_waddr_b_q <= '0;
            rf_wdata_a_q <= '0;
            rf_wdata_b_q <= '0;
            raddr_ra_q   <= '0;
            raddr_rb_q   <= '0;
            raddr_rc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            setback_q    <= setback_d;
            recover_q    <= recover_d;
            backup_q     <= backup_d;
            rf_we_a_q    <= rf_we_a_d;
            rf_we_b_q    <= rf_we_b_d;
            rf_waddr_a_q <= rf_waddr_a_d;
            rf_waddr_b_q <= rf_waddr_b_d;
            rf_wdata_a_q <= rf_wdata_a_d;
            rf_wdata_b_q <= rf_wdata_b_d;
            raddr_ra_q   <= raddr_ra_d;
            raddr_rb_q   <= raddr_rb_d;
            raddr_rc_q   <= raddr_rc_d;
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign rf_if.setback_o    = setback_q;
    assign rf_if.recover_o    = recover_q;
    assign rf_if.backup_o     = backup_q;
    assign rf_if.rf_we_a_o    = rf_we_a_q;
    assign rf_if.rf_we_b_o    = rf_we_b_q;
    assign rf_if.rf_waddr_a_o = rf_waddr_a_q;
    assign rf_if.rf_waddr_b_o = rf_waddr_b_q;
    assign rf_if.rf_wdata_a_o = rf_wdata_a_q;
    assign rf_if.rf_wdata_b_o = rf_wdata_b_q;
    assign rf_if.raddr_ra_o   = raddr_ra_q;
    assign rf_if.raddr_rb_o   = raddr_rb_q;
    assign rf_if.raddr_rc_o   = raddr_rc_q;

endmodule

// File: tb/tb_cv32e40p_rf_recovery_unit.sv
// Self-checking bench for cv32e40p_rf_recovery_unit (NUM_REGS=32).
// Reference: an array of expected shadow contents updated from the rules
// (writes to 1..31 only, B after A, snapshot copies the core RF wholesale).
module tb_cv32e40p_rf_recovery_unit;

    logic clk = 1'b0;
    logic rst;
    logic snap_req;
    logic rec_req;
    logic busy;
    logic done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m       [32];
    logic [31:0] core_rf [64];

    cv32e40p_rf_recovery_unit_if rf_if ();

    cv32e40p_rf_recovery_unit #(
        .NUM_REGS (32),
        .ADDR_W   (6)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .snapshot_req_i (snap_req),
        .recover_req_i  (rec_req),
        .busy_o         (busy),
        .done_o         (done),
        .rf_if          (rf_if)
    );

    always #5 clk = ~clk;

    assign rf_if.rdata_ra_i = core_rf[rf_if.raddr_ra_o];
    assign rf_if.rdata_rb_i = core_rf[rf_if.raddr_rb_o];
    assign rf_if.rdata_rc_i = core_rf[rf_if.raddr_rc_o];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bitmap of output activity:
    // [13]busy [12]done [11]setback [10]recover [9]backup [8]we_a [7]we_b
    // [6]waddr_a [5]waddr_b [4]wdata_a [3]wdata_b [2]raddr_ra [1]raddr_rb [0]raddr_rc
    function automatic logic [31:0] activity();
        return 32'({busy, done, rf_if.setback_o, rf_if.recover_o, rf_if.backup_o,
                    rf_if.rf_we_a_o, rf_if.rf_we_b_o,
                    |rf_if.rf_waddr_a_o, |rf_if.rf_waddr_b_o,
                    |rf_if.rf_wdata_a_o, |rf_if.rf_wdata_b_o,
                    |rf_if.raddr_ra_o, |rf_if.raddr_rb_o, |rf_if.raddr_rc_o});
    endfunction

    task automatic core_write(input logic wa, input logic [5:0] aa, input logic [31:0] da,
                              input logic wb, input logic [5:0] bb, input logic [31:0] db);
        rf_if.core_we_a_i    = wa;
        rf_if.core_waddr_a_i = aa;
        rf_if.core_wdata_a_i = da;
        rf_if.core_we_b_i    = wb;
        rf_if.core_waddr_b_i = bb;
        rf_if.core_wdata_b_i = db;
        tick();
        if (wa && aa != 0 && aa < 32) m[aa] = da;
        if (wb && bb != 0 && bb < 32) m[bb] = db;
        if (wa && aa != 0) core_rf[aa] = da;
        if (wb && bb != 0) core_rf[bb] = db;
        rf_if.core_we_a_i = 1'b0;
        rf_if.core_we_b_i = 1'b0;
    endtask

    task automatic scramble_core();
        for (int a = 0; a < 64; a++) core_rf[a] = $urandom;
    endtask

    // Entered just after the setback cycle has been observed.
    task automatic restore_tail(input int poke_k);
        for (int k = 0; k < 16; k++) begin
            tick();
            snap_req = 1'b0;
            rec_req  = 1'b0;
            chk("restore_ctrl", 32'({busy, done, rf_if.setback_o, rf_if.recover_o, rf_if.backup_o,
                                     rf_if.rf_we_a_o, rf_if.rf_we_b_o}), 32'b1001011);
            chk("restore_waddr_a", 32'(rf_if.rf_waddr_a_o), 32'(2 * k));
            chk("restore_waddr_b", 32'(rf_if.rf_waddr_b_o), 32'(2 * k + 1));
            chk("restore_wdata_a", rf_if.rf_wdata_a_o, m[2 * k]);
            chk("restore_wdata_b", rf_if.rf_wdata_b_o, m[2 * k + 1]);
            if (k == poke_k) begin
                snap_req = 1'b1;
                rec_req  = 1'b1;
            end
        end
        tick();
        snap_req = 1'b0;
        rec_req  = 1'b0;
        chk("restore_done", activity(), 32'h1000);
        tick();
        chk("restore_after", activity(), 32'h0);
        for (int a = 0; a < 32; a++) core_rf[a] = m[a];
    endtask

    task automatic do_recover(input int poke_k);
        rec_req = 1'b1;
        tick();
        rec_req = 1'b0;
        chk("setback_cycle", activity(), 32'h2800);
        restore_tail(poke_k);
    endtask

    task automatic do_snapshot(input int rec_at);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        for (int c = 0; c < 11; c++) begin
            chk("snap_ctrl", 32'({busy, rf_if.backup_o, done, rf_if.setback_o, rf_if.recover_o}), 32'b11000);
            chk("snap_raddr_ra", 32'(rf_if.raddr_ra_o), 32'(3 * c));
            chk("snap_raddr_rb", 32'(rf_if.raddr_rb_o), 32'(3 * c + 1));
            chk("snap_raddr_rc", 32'(rf_if.raddr_rc_o), 32'(3 * c + 2));
            // A core write during the snapshot must not reach the shadow.
            rf_if.core_we_a_i    = (c == 4);
            rf_if.core_waddr_a_i = 6'd7;
            rf_if.core_wdata_a_i = $urandom;
            rec_req              = (c == rec_at);
            tick();
            rf_if.core_we_a_i = 1'b0;
            rec_req           = 1'b0;
        end
        for (int a = 1; a < 32; a++) m[a] = core_rf[a];
        if (rec_at < 0) begin
            chk("snap_done", activity(), 32'h1000);
            tick();
            chk("snap_after", activity(), 32'h0);
        end else begin
            chk("snap_pending_setback", activity(), 32'h2800);
            restore_tail(-1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        snap_req = 1'b0;
        rec_req  = 1'b0;
        rf_if.core_we_a_i    = 1'b0;
        rf_if.core_waddr_a_i = '0;
        rf_if.core_wdata_a_i = '0;
        rf_if.core_we_b_i    = 1'b0;
        rf_if.core_waddr_b_i = '0;
        rf_if.core_wdata_b_i = '0;
        for (int a = 0; a < 32; a++) m[a] = '0;
        scramble_core();

        tick();
        tick();
        chk("reset_outputs", activity(), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", activity(), 32'h0);

        // Directed tracking: same-address B priority, x0 ignored, out-of-range ignored.
        core_write(1'b1, 6'd5,  32'hDEADBEEF, 1'b1, 6'd5,  32'h12345678);
        core_write(1'b1, 6'd0,  32'hFFFFFFFF, 1'b0, 6'd0,  32'h0);
        core_write(1'b1, 6'd40, 32'hAAAAAAAA, 1'b1, 6'd3,  32'h33333333);
        core_write(1'b1, 6'd31, 32'h31313131, 1'b1, 6'd32, 32'hBBBBBBBB);
        core_write(1'b0, 6'd9,  32'h99999999, 1'b1, 6'd1,  32'h11111111);
        do_recover(5);

        // Randomized tracking traffic.
        for (int n = 0; n < 60; n++) begin
            core_write(1'($urandom), 6'($urandom_range(0, 40)), $urandom,
                       1'($urandom), 6'($urandom_range(0, 40)), $urandom);
        end
        do_recover(-1);

        // Snapshot from a scrambled core RF, then restore it back.
        scramble_core();
        do_snapshot(-1);
        do_recover(-1);

        // Recovery raised during the snapshot.
        for (int n = 0; n < 10; n++) begin
            core_write(1'($urandom), 6'($urandom_range(0, 31)), $urandom,
                       1'($urandom), 6'($urandom_range(0, 31)), $urandom);
        end
        scramble_core();
        do_snapshot(3);

        // Both requests together: recovery wins, snapshot dropped.
        scramble_core();
        snap_req = 1'b1;
        rec_req  = 1'b1;
        tick();
        snap_req = 1'b0;
        rec_req  = 1'b0;
        chk("both_req_setback", activity(), 32'h2800);
        restore_tail(-1);

        // Reset in the middle of a restore.
        rec_req = 1'b1;
        tick();
        rec_req = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("mid_restore_k7", 32'(rf_if.rf_waddr_a_o), 32'd14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_mid_restore", activity(), 32'h0);
        for (int a = 0; a < 32; a++) m[a] = '0;
        tick();
        chk("reset_no_done", activity(), 32'h0);
        do_recover(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
